// File: rtl/mu_sweep_seq.sv
// Delay-code sweep sequencer for the measure unit.
// Programmed over a Wishbone slave port; runs each sweep point as Wishbone master transfers.
module mu_sweep_seq #(
    parameter logic [31:0] MU_BASE    = 32'h0500_0000,
    parameter logic [7:0]  OFS_DELAY  = 8'h00,
    parameter logic [7:0]  OFS_CTRL   = 8'h04,
    parameter logic [7:0]  OFS_STAT   = 8'h08,
    parameter logic [7:0]  OFS_RES    = 8'h0C,
    parameter int          DONE_BIT   = 0,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_stall_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i,
    output logic        irq_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_CODE  = 3'd1;
    localparam logic [2:0] WR_START = 3'd2;
    localparam logic [2:0] POLL     = 3'd3;
    localparam logic [2:0] RD_RES   = 3'd4;
    localparam logic [2:0] WR_DST   = 3'd5;
    localparam logic [2:0] NEXT     = 3'd6;
    localparam logic [2:0] FINISH   = 3'd7;

    localparam int PW = $clog2(POLL_LIMIT + 1);

    logic [2:0]    state;
    logic [9:0]    cfg_code, cfg_step;
    logic [15:0]   cfg_count;
    logic [31:0]   cfg_dst;
    logic [9:0]    code_run, step_run;
    logic [15:0]   remaining;
    logic [31:0]   dst_ptr, result;
    logic [PW-1:0] poll_cnt;
    logic          done, timeout, buserr, aborted;
    logic          busy, s_req, s_wr, start_req, abort_req;
    logic          unused_ok;

    assign busy      = (state != IDLE) && (state != FINISH);
    assign s_req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign s_wr      = s_req & wbs_we_i;
    assign start_req = s_wr && wbs_adr_i[3:2] == 2'd0 && wbs_dat_i[0] && !busy;
    assign abort_req = s_wr && wbs_adr_i[3:2] == 2'd0 && wbs_dat_i[1] && busy;

    assign wbs_stall_o = 1'b0;
    assign wbm_sel_o   = 4'hF;
    assign irq_o       = (state == FINISH);
    assign unused_ok   = ^{wbs_sel_i, wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            cfg_code  <= '0;
            cfg_step  <= '0;
            cfg_count <= '0;
            cfg_dst   <= '0;
        end else begin
            wbs_ack_o <= s_req;
            if (s_req && !wbs_we_i) begin
                case (wbs_adr_i[3:2])
                    2'd0:    wbs_dat_o <= {28'b0, buserr, timeout, done, busy};
                    2'd1:    wbs_dat_o <= {6'b0, cfg_step, 6'b0, cfg_code};
                    2'd2:    wbs_dat_o <= {16'b0, cfg_count};
                    default: wbs_dat_o <= cfg_dst;
                endcase
            end
            if (s_wr && !busy) begin
                case (wbs_adr_i[3:2])
                    2'd1: begin
                        cfg_code <= wbs_dat_i[9:0];
                        cfg_step <= wbs_dat_i[25:16];
                    end
                    2'd2:    cfg_count <= wbs_dat_i[15:0];
                    2'd3:    cfg_dst   <= {wbs_dat_i[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_we_o  = 1'b0;
        case (state)
            WR_CODE: begin
                wbm_adr_o = MU_BASE + {24'b0, OFS_DELAY};
                wbm_dat_o = {22'b0, code_run};
                wbm_we_o  = 1'b1;
            end
            WR_START: begin
                wbm_adr_o = MU_BASE + {24'b0, OFS_CTRL};
                wbm_dat_o = 32'h1;
                wbm_we_o  = 1'b1;
            end
            POLL:    wbm_adr_o = MU_BASE + {24'b0, OFS_STAT};
            RD_RES:  wbm_adr_o = MU_BASE + {24'b0, OFS_RES};
            WR_DST: begin
                wbm_adr_o = dst_ptr;
                wbm_dat_o = result;
                wbm_we_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            code_run  <= '0;
            step_run  <= '0;
            remaining <= '0;
            dst_ptr   <= '0;
            result    <= '0;
            poll_cnt  <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            buserr    <= 1'b0;
            aborted   <= 1'b0;
        end else if (start_req) begin
            done      <= 1'b0;
            timeout   <= 1'b0;
            buserr    <= 1'b0;
            aborted   <= 1'b0;
            code_run  <= cfg_code;
            step_run  <= cfg_step;
            remaining <= cfg_count;
            dst_ptr   <= cfg_dst;
            state     <= (cfg_count == 16'd0) ? FINISH : WR_CODE;
        end else begin
            if (abort_req)
                aborted <= 1'b1;
            case (state)
                IDLE: ;
                FINISH: begin
                    done  <= !(aborted || timeout || buserr);
                    state <= IDLE;
                end
                NEXT:
                    state <= (aborted || remaining == 16'd0) ? FINISH : WR_CODE;
                default: begin
                    // Abort between transfers: nothing outstanding, stop now
                    if (!wbm_cyc_o) begin
                        if (aborted || abort_req) begin
                            state <= FINISH;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                        end
                    end else begin
                        if (wbm_stb_o && !wbm_stall_i)
                            wbm_stb_o <= 1'b0;
                        if (wbm_err_i) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            buserr    <= 1'b1;
                            state     <= FINISH;
                        end else if (wbm_ack_i) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            if (aborted || abort_req) begin
                                state <= FINISH;
                            end else begin
                                case (state)
                                    WR_CODE: state <= WR_START;
                                    WR_START: begin
                                        poll_cnt <= '0;
                                        state    <= POLL;
                                    end
                                    POLL: begin
                                        if (wbm_dat_i[DONE_BIT]) begin
                                            state <= RD_RES;
                                        end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                                            timeout <= 1'b1;
                                            state   <= FINISH;
                                        end else begin
                                            poll_cnt <= poll_cnt + 1'b1;
                                        end
                                    end
                                    RD_RES: begin
                                        result <= wbm_dat_i;
                                        state  <= WR_DST;
                                    end
                                    default: begin
                                        dst_ptr   <= dst_ptr + 32'd4;
                                        code_run  <= code_run + step_run;
                                        remaining <= remaining - 16'd1;
                                        state     <= NEXT;
                                    end
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mu_sweep_seq.sv
// Directed bench for mu_sweep_seq with a measure-unit and RAM model on the master port.
// POLL_LIMIT is overridden to 4 so the timeout path is short.
module tb_mu_sweep_seq;

    localparam logic [31:0] MU = 32'h0500_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [3:0]  s_adr = '0;
    logic [31:0] s_dat = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_stall_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] m_rdat = '0;
    logic        m_ack = 1'b0, m_err = 1'b0;
    logic        wbm_stall_i;
    logic        irq_o;

    always #5 clk = ~clk;

    mu_sweep_seq #(.POLL_LIMIT(4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_we_i(s_we),
        .wbs_adr_i(s_adr), .wbs_dat_i(s_dat), .wbs_sel_i(4'hF),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_stall_o(wbs_stall_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(m_rdat), .wbm_ack_i(m_ack), .wbm_err_i(m_err),
        .wbm_stall_i(wbm_stall_i), .irq_o(irq_o)
    );

    // model controls, written only by the stimulus process
    int   done_after = 1;
    int   stall_req  = 0;
    int   err_at     = 32'hFFFF;
    logic hold_stat  = 1'b0;

    // model state and logs, written only by the model process
    logic [31:0] ram [0:63] = '{default: 32'h0};
    logic [31:0] dly_log [0:31] = '{default: 32'h0};
    int dly_n = 0, stat_n = 0, res_n = 0, dst_n = 0, dst_att = 0;
    int ctrl_n = 0, stall_seen = 0, irq_n = 0, pp = 0;
    logic [9:0]  last_code = '0;
    logic        pend = 1'b0, pend_err = 1'b0, pend_stat = 1'b0;
    logic [31:0] pend_dat = '0;

    assign wbm_stall_i = wbm_cyc_o && wbm_stb_o && wbm_we_o &&
                         wbm_adr_o == MU + 32'h4 && stall_seen < stall_req;

    always @(posedge clk) begin
        if (irq_o)
            irq_n <= irq_n + 1;
        if (wbm_stall_i)
            stall_seen <= stall_seen + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            m_ack <= 1'b0;
            m_err <= 1'b0;
        end else begin
            m_ack <= 1'b0;
            m_err <= 1'b0;
            if (pend && !(hold_stat && pend_stat)) begin
                pend   <= 1'b0;
                m_rdat <= pend_dat;
                if (pend_err) m_err <= 1'b1;
                else m_ack <= 1'b1;
            end
            if (wbm_cyc_o && wbm_stb_o && !wbm_stall_i) begin
                pend      <= 1'b1;
                pend_err  <= 1'b0;
                pend_stat <= 1'b0;
                pend_dat  <= '0;
                if (wbm_adr_o == MU && wbm_we_o) begin
                    dly_log[dly_n[4:0]] <= wbm_dat_o;
                    dly_n     <= dly_n + 1;
                    last_code <= wbm_dat_o[9:0];
                end else if (wbm_adr_o == MU + 32'h4 && wbm_we_o) begin
                    ctrl_n <= ctrl_n + 1;
                    pp     <= 0;
                end else if (wbm_adr_o == MU + 32'h8) begin
                    stat_n    <= stat_n + 1;
                    pp        <= pp + 1;
                    pend_stat <= 1'b1;
                    pend_dat  <= {31'b0, (pp + 1 >= done_after)};
                end else if (wbm_adr_o == MU + 32'hC) begin
                    res_n    <= res_n + 1;
                    pend_dat <= 32'hA000_0000 | {22'b0, last_code};
                end else if (wbm_we_o) begin
                    dst_att <= dst_att + 1;
                    if (dst_att == err_at) begin
                        pend_err <= 1'b1;
                    end else begin
                        ram[wbm_adr_o[7:2]] <= wbm_dat_o;
                        dst_n <= dst_n + 1;
                    end
                end
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wbs_xfer(input logic we, input logic [3:0] adr,
                            input logic [31:0] d, output logic [31:0] q);
        int k = 0;
        @(posedge clk); #1;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = adr; s_dat = d;
        do begin
            @(posedge clk); #1; k++;
        end while (!wbs_ack_o && k < 10);
        q = wbs_dat_o;
        if (!wbs_ack_o) chk("slave_ack", 32'h0, 32'h1);
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] d);
        logic [31:0] q;
        wbs_xfer(1'b1, adr, d, q);
    endtask

    task automatic rd(input logic [3:0] adr, output logic [31:0] q);
        wbs_xfer(1'b0, adr, 32'h0, q);
    endtask

    task automatic wait_irq(input string tag);
        int base = irq_n;
        int k = 0;
        while (irq_n == base && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, irq_n - base, 1);
    endtask

    task automatic wait_stat(input int base);
        int k = 0;
        while (stat_n == base && k < 500) begin
            @(posedge clk); #1; k++;
        end
        if (stat_n == base) chk("stat_wait", 32'h0, 32'h1);
    endtask

    logic [31:0] q;
    int b_dly, b_stat, b_res, b_dst, b_ctrl;

    task automatic snap();
        b_dly = dly_n; b_stat = stat_n; b_res = res_n;
        b_dst = dst_n; b_ctrl = ctrl_n;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rd(4'h0, q);   chk("rst_ctrl", q, 32'h0);
        rd(4'h4, q);   chk("rst_code", q, 32'h0);
        chk("rst_cyc", {30'b0, wbm_cyc_o, irq_o}, 32'h0);

        // three points, MU done on first poll
        snap();
        wr(4'h4, 32'h0001_0005);
        wr(4'h8, 32'd3);
        wr(4'hC, 32'h0400_0100);
        wr(4'h0, 32'h1);
        wait_irq("sweep_irq");
        chk("sweep_ndly", dly_n - b_dly, 3);
        chk("sweep_dly0", dly_log[b_dly], 32'h5);
        chk("sweep_dly1", dly_log[b_dly + 1], 32'h6);
        chk("sweep_dly2", dly_log[b_dly + 2], 32'h7);
        chk("sweep_ram0", ram[0], 32'hA000_0005);
        chk("sweep_ram1", ram[1], 32'hA000_0006);
        chk("sweep_ram2", ram[2], 32'hA000_0007);
        rd(4'h0, q);   chk("sweep_ctrl", q, 32'h2);
        rd(4'h4, q);   chk("sweep_code", q, 32'h0001_0005);

        // code wrap modulo 1024
        snap();
        wr(4'h4, 32'h0003_03FE);
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h1);
        wait_irq("wrap_irq");
        chk("wrap_ndly", dly_n - b_dly, 2);
        chk("wrap_dly0", dly_log[b_dly], 32'h3FE);
        chk("wrap_dly1", dly_log[b_dly + 1], 32'h001);

        // MU never done
        snap();
        done_after = 1000;
        wr(4'h8, 32'd1);
        wr(4'h0, 32'h1);
        wait_irq("tmo_irq");
        chk("tmo_nstat", stat_n - b_stat, 4);
        chk("tmo_nres", res_n - b_res, 0);
        chk("tmo_ndst", dst_n - b_dst, 0);
        rd(4'h0, q);   chk("tmo_ctrl", q, 32'h4);

        // stalled start write
        snap();
        done_after = 1;
        stall_req  = stall_seen + 5;
        wr(4'h0, 32'h1);
        wait_irq("stall_irq");
        chk("stall_cycles", stall_seen, stall_req);
        chk("stall_nctrl", ctrl_n - b_ctrl, 1);
        chk("stall_ndst", dst_n - b_dst, 1);
        rd(4'h0, q);   chk("stall_ctrl", q, 32'h2);

        // bus error on second destination write
        snap();
        err_at = dst_att + 1;
        wr(4'h4, 32'h0001_0005);
        wr(4'h8, 32'd3);
        wr(4'hC, 32'h0400_0140);
        wr(4'h0, 32'h1);
        wait_irq("err_irq");
        err_at = 32'hFFFF;
        chk("err_ram0", ram[16], 32'hA000_0005);
        chk("err_ram1", ram[17], 32'h0);
        chk("err_ndly", dly_n - b_dly, 2);
        rd(4'h0, q);   chk("err_ctrl", q, 32'h8);

        // abort while a status read is waiting for ack
        snap();
        hold_stat = 1'b1;
        wr(4'h0, 32'h1);
        wait_stat(b_stat);
        wr(4'h0, 32'h2);
        rd(4'h0, q);   chk("abort_busy", q, 32'h1);
        hold_stat = 1'b0;
        wait_irq("abort_irq");
        chk("abort_ndst", dst_n - b_dst, 0);
        rd(4'h0, q);   chk("abort_ctrl", q, 32'h0);

        // reset in the middle of an outstanding read
        snap();
        hold_stat = 1'b1;
        wr(4'h0, 32'h1);
        wait_stat(b_stat);
        chk("pre_rst_cyc", {31'b0, wbm_cyc_o}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        chk("rst_mid_stb", {31'b0, wbm_stb_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hold_stat = 1'b0;
        rd(4'h0, q);   chk("rst_mid_ctrl", q, 32'h0);
        rd(4'hC, q);   chk("rst_mid_dst", q, 32'h0);
        rd(4'h8, q);   chk("rst_mid_cnt", q, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
